// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, addresses the combinational
// program ROM, registers the returned word and hands it to decode with a
// valid/ready handshake. Redirects flush the held word; misaligned or
// out-of-range fetch addresses park the block in a terminal fault state.
module fetch_controller #(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0]  BASE_ADDRESS = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic                  Ready_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Target_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PC_plus4_o,
  output logic                  Valid_o,
  output logic                  Fault_o,
  output logic [DATA_WIDTH-1:0] Fault_addr_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Byte span of the ROM and the word stride, sized to the datapath.
  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(32'd4 * MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(32'd4);

  state_t                state_r, state_n;
  logic [DATA_WIDTH-1:0] pc_r, pc_n;
  logic [DATA_WIDTH-1:0] instr_r, instr_n;
  logic [DATA_WIDTH-1:0] pc_out_r, pc_out_n;
  logic                  valid_r, valid_n;
  logic                  fault_r, fault_n;
  logic [DATA_WIDTH-1:0] fault_addr_r, fault_addr_n;

  logic [DATA_WIDTH-1:0] pc_offset_s;
  logic [DATA_WIDTH-1:0] pc_plus4_s;
  logic                  pc_aligned_s;
  logic                  pc_in_range_s;
  logic                  pc_legal_s;

  // Legality of the PC about to be fetched. The lower-bound compare also
  // keeps a wrapped PC (near 2^DATA_WIDTH) from aliasing into the window.
  always_comb begin
    pc_offset_s   = pc_r - BASE_ADDRESS;
    pc_plus4_s    = pc_r + FOUR;
    pc_aligned_s  = (pc_r[1:0] == 2'b00);
    pc_in_range_s = (pc_r >= BASE_ADDRESS) && (pc_offset_s < SPAN);
    pc_legal_s    = pc_aligned_s && pc_in_range_s;
  end

  // Next-state and next-register logic; every register holds unless an
  // arm below updates it.
  always_comb begin
    state_n      = state_r;
    pc_n         = pc_r;
    instr_n      = instr_r;
    pc_out_n     = pc_out_r;
    valid_n      = valid_r;
    fault_n      = fault_r;
    fault_addr_n = fault_addr_r;
    case (state_r)
      IDLE: begin
        valid_n = 1'b0;
        // Redirect and Start may both act in the same cycle.
        if (Redirect_i) begin
          pc_n = Target_i;
        end else begin
          pc_n = pc_r;
        end
        if (Start_i) begin
          state_n = FETCH;
        end else begin
          state_n = IDLE;
        end
      end
      FETCH: begin
        if (Redirect_i) begin
          // Flush wins over a pending handshake; the target is only
          // checked when it is actually fetched.
          valid_n = 1'b0;
          pc_n    = Target_i;
        end else if (!pc_legal_s) begin
          state_n      = FAULT;
          fault_n      = 1'b1;
          fault_addr_n = pc_r;
          valid_n      = 1'b0;
        end else if (!valid_r || Ready_i) begin
          instr_n  = Instruction_i;
          pc_out_n = pc_r;
          valid_n  = 1'b1;
          pc_n     = pc_plus4_s;
        end else begin
          // Decode is stalling: hold everything, Address_o included.
          valid_n = valid_r;
        end
      end
      FAULT: begin
        valid_n = 1'b0;
      end
      default: begin
        // An unreachable encoding is treated as a fault so fetch stops.
        state_n      = FAULT;
        fault_n      = 1'b1;
        fault_addr_n = pc_r;
        valid_n      = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      pc_r         <= BASE_ADDRESS;
      instr_r      <= '0;
      pc_out_r     <= '0;
      valid_r      <= 1'b0;
      fault_r      <= 1'b0;
      fault_addr_r <= '0;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      instr_r      <= instr_n;
      pc_out_r     <= pc_out_n;
      valid_r      <= valid_n;
      fault_r      <= fault_n;
      fault_addr_r <= fault_addr_n;
    end
  end

  assign Address_o     = pc_r;
  assign Instruction_o = instr_r;
  assign PC_o          = pc_out_r;
  assign PC_plus4_o    = pc_out_r + FOUR;
  assign Valid_o       = valid_r;
  assign Fault_o       = fault_r;
  assign Fault_addr_o  = fault_addr_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: random ROM contents, a transaction-level
// reference model of the fetch rules, and directed scenario tasks.
module tb_fetch_controller;

  localparam logic [31:0] BASE = 32'h00400000;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_FAULT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, ready_i, redirect_i;
  logic [31:0] target_i, instr_i;
  logic [31:0] addr_o, instr_o, pc_o, pc_plus4_o, fault_addr_o;
  logic        valid_o, fault_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] rom [64];

  // Reference model state.
  int          m_state;
  logic [31:0] m_pc, m_ir, m_pco, m_faddr;
  logic        m_valid, m_fault;

  logic [161:0] got_v;
  logic [161:0] exp_v;

  fetch_controller dut (
    .clk          (clk),
    .reset        (reset),
    .Start_i      (start_i),
    .Ready_i      (ready_i),
    .Redirect_i   (redirect_i),
    .Target_i     (target_i),
    .Instruction_i(instr_i),
    .Address_o    (addr_o),
    .Instruction_o(instr_o),
    .PC_o         (pc_o),
    .PC_plus4_o   (pc_plus4_o),
    .Valid_o      (valid_o),
    .Fault_o      (fault_o),
    .Fault_addr_o (fault_addr_o)
  );

  always #5 clk = ~clk;

  function automatic logic legal(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && (a >= BASE) && (off < 32'd256);
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (legal(a)) return rom[off[7:2]];
    else return 32'hBAD0BAD0;
  endfunction

  // Combinational program ROM seen by the DUT.
  always_comb instr_i = rom_word(addr_o);

  assign got_v = {valid_o, fault_o, instr_o, pc_o, addr_o, fault_addr_o, pc_plus4_o};
  assign exp_v = {m_valid, m_fault, m_ir, m_pco, m_pc, m_faddr, m_pco + 32'd4};

  task automatic model_reset();
    m_state = M_IDLE; m_pc = BASE; m_ir = 32'd0; m_pco = 32'd0;
    m_faddr = 32'd0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  // What one rising edge does, stated from the fetch rules.
  task automatic model_edge(input logic s, input logic r, input logic d, input logic [31:0] t);
    if (m_state == M_IDLE) begin
      m_valid = 1'b0;
      if (d) m_pc = t;
      if (s) m_state = M_FETCH;
    end else if (m_state == M_FETCH) begin
      if (d) begin
        m_valid = 1'b0; m_pc = t;
      end else if (!legal(m_pc)) begin
        m_state = M_FAULT; m_fault = 1'b1; m_faddr = m_pc; m_valid = 1'b0;
      end else if (!m_valid || r) begin
        m_ir = rom_word(m_pc); m_pco = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Drive inputs on the falling edge, advance one rising edge, settle.
  task automatic tick(input logic s, input logic r, input logic d, input logic [31:0] t);
    start_i = s; ready_i = r; redirect_i = d; target_i = t;
    model_edge(s, r, d, t);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    start_i = 1'b0; ready_i = 1'b0; redirect_i = 1'b0; target_i = 32'd0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    start_i = 1'b0; ready_i = 1'b0; redirect_i = 1'b0; target_i = 32'd0;
    reset = 1'b0;
    #3;
    total++;
    if (got_v !== {1'b0, 1'b0, 32'd0, 32'd0, BASE, 32'd0, 32'd4}) begin
      bad++; $display("FAIL reset_values got=%h exp=%h", got_v,
                      {1'b0, 1'b0, 32'd0, 32'd0, BASE, 32'd0, 32'd4});
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_start();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    total++;
    if (got_v !== exp_v || valid_o !== 1'b0) begin
      bad++; $display("FAIL start_edge1 got=%h exp=%h", got_v, exp_v);
    end
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    total++;
    if (valid_o !== 1'b1 || pc_o !== BASE || instr_o !== 32'h20080005) begin
      bad++; $display("FAIL start_edge2 got v=%b pc=%h ir=%h exp v=1 pc=%h ir=20080005",
                      valid_o, pc_o, instr_o, BASE);
    end
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    total++;
    if (pc_o !== 32'h00400004 || instr_o !== 32'h20090003 || pc_plus4_o !== 32'h00400008) begin
      bad++; $display("FAIL start_edge3 got pc=%h ir=%h p4=%h exp 00400004 20090003 00400008",
                      pc_o, instr_o, pc_plus4_o);
    end
    total++;
    if (got_v !== exp_v) begin
      bad++; $display("FAIL start_model got=%h exp=%h", got_v, exp_v);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ir0, pc0, a0;
    ir0 = instr_o; pc0 = pc_o; a0 = addr_o;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'd0);
      total++;
      if (instr_o !== ir0 || pc_o !== pc0 || addr_o !== a0 || valid_o !== 1'b1 || got_v !== exp_v) begin
        bad++; $display("FAIL stall_hold got ir=%h pc=%h a=%h exp ir=%h pc=%h a=%h",
                        instr_o, pc_o, addr_o, ir0, pc0, a0);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    total++;
    if (pc_o !== pc0 + 32'd4 || got_v !== exp_v) begin
      bad++; $display("FAIL stall_release got pc=%h exp=%h", pc_o, pc0 + 32'd4);
    end
  endtask

  task automatic test_redirect();
    tick(1'b0, 1'b1, 1'b1, 32'h00400020);
    total++;
    if (valid_o !== 1'b0 || addr_o !== 32'h00400020) begin
      bad++; $display("FAIL redirect_flush got v=%b a=%h exp v=0 a=00400020", valid_o, addr_o);
    end
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h00400020 || instr_o !== rom[8]) begin
      bad++; $display("FAIL redirect_target got v=%b pc=%h ir=%h exp v=1 pc=00400020 ir=%h",
                      valid_o, pc_o, instr_o, rom[8]);
    end
  endtask

  task automatic test_idle_redirect_start();
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 32'h00400040);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    total++;
    if (pc_o !== 32'h00400040 || valid_o !== 1'b1 || got_v !== exp_v) begin
      bad++; $display("FAIL idle_redir_start got pc=%h v=%b exp pc=00400040 v=1", pc_o, valid_o);
    end
  endtask

  task automatic test_random();
    logic r, d;
    logic [31:0] t;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 300; i++) begin
      r = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 7) == 0);
      t = BASE + {22'd0, 6'($urandom_range(0, 63)), 2'b00};
      tick(1'b0, r, d, t);
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL random_cycle%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_run_off_end();
    do_reset();
    tick(1'b1, 1'b1, 1'b1, 32'h004000F8);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);
    total++;
    if (fault_o !== 1'b1 || fault_addr_o !== 32'h00400100 || valid_o !== 1'b0 ||
        pc_o !== 32'h004000FC || got_v !== exp_v) begin
      bad++; $display("FAIL off_end got f=%b fa=%h v=%b pc=%h exp f=1 fa=00400100 v=0 pc=004000fc",
                      fault_o, fault_addr_o, valid_o, pc_o);
    end
    tick(1'b1, 1'b1, 1'b1, BASE);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    total++;
    if (fault_o !== 1'b1 || addr_o !== 32'h00400100 || valid_o !== 1'b0 || got_v !== exp_v) begin
      bad++; $display("FAIL fault_sticky got f=%b a=%h v=%b exp f=1 a=00400100 v=0",
                      fault_o, addr_o, valid_o);
    end
  endtask

  task automatic test_bad_target(input logic [31:0] t);
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b1, t);
    total++;
    if (fault_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++; $display("FAIL bad_target_early t=%h got f=%b v=%b exp f=0 v=0", t, fault_o, valid_o);
    end
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    total++;
    if (fault_o !== 1'b1 || fault_addr_o !== t || got_v !== exp_v) begin
      bad++; $display("FAIL bad_target t=%h got f=%b fa=%h exp f=1 fa=%h", t, fault_o, fault_addr_o, t);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (got_v !== {1'b0, 1'b0, 32'd0, 32'd0, BASE, 32'd0, 32'd4}) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", got_v,
                      {1'b0, 1'b0, 32'd0, 32'd0, BASE, 32'd0, 32'd4});
    end
    start_i = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 32'd0);
      total++;
      if (valid_o !== 1'b0 || addr_o !== BASE || got_v !== exp_v) begin
        bad++; $display("FAIL post_reset_idle got v=%b a=%h exp v=0 a=%h", valid_o, addr_o, BASE);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h20080005;
    rom[1] = 32'h20090003;
    reset = 1'b1;
    start_i = 1'b0; ready_i = 1'b0; redirect_i = 1'b0; target_i = 32'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_start();
    test_stall();
    test_redirect();
    test_idle_redirect_start();
    test_random();
    test_run_off_end();
    test_bad_target(32'h00400006);
    test_bad_target(32'h003FFFFC);
    test_bad_target(32'hFFFFFFFC);
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
